// File: rtl/video_frame_cmd_gen.sv
// Frame-buffer write command generator: splits each video line into AXI bursts
// and walks a rotating set of frame buffers. Optional macro: VIDEO_FRAME_REVERSE_EN.
module video_frame_cmd_gen #(
    parameter int          AXI_DATA_WIDTH   = 128,
    parameter int          AXI_ADDR_WIDTH   = 32,
    parameter int          PIXEL_WIDTH      = 16,
    parameter int          MAX_BURST_LEN    = 64,
    parameter int          FRAME_BUF_NUM    = 3,
    parameter logic [31:0] FRAME_BUF_STRIDE = 32'h0080_0000
) (
    input  logic                      i_axi_clk,
    input  logic                      i_reset_n,
    input  logic                      i_frame_start,
    input  logic [15:0]               i_video_width,
    input  logic [15:0]               i_video_high,
    input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
    input  logic                      i_frame_mode,
    output logic                      o_cmd_valid,
    input  logic                      i_cmd_ready,
    output logic [AXI_ADDR_WIDTH-1:0] o_cmd_addr,
    output logic [7:0]                o_cmd_len,
    output logic                      o_cmd_line_last,
    output logic                      o_cmd_frame_last,
    output logic [2:0]                o_buf_idx,
    output logic                      o_busy,
    output logic                      o_frame_drop,
    output logic [1:0]                o_dbg_state
);

    // Handshake: a command transfers on a rising clock edge where o_cmd_valid
    // and i_cmd_ready are both high; while valid is high and ready is low the
    // command fields do not change, and valid never drops without a transfer.

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_CMD} state_t;

    localparam logic [31:0] BEAT_BYTES  = 32'(AXI_DATA_WIDTH / 8);
    localparam logic [31:0] MAX_BEATS   = 32'(MAX_BURST_LEN);
    localparam logic [31:0] BURST_BYTES = MAX_BEATS * BEAT_BYTES;
    localparam logic [2:0]  LAST_BUF    = 3'(FRAME_BUF_NUM - 1);

    state_t                    state_q, state_d;
    logic [2:0]                buf_q, buf_d;
    logic [15:0]               width_q, width_d;
    logic [15:0]               high_q, high_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]               stride_q, stride_d;
    logic [31:0]               bpl_q, bpl_d;
    logic [AXI_ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [31:0]               off_q, off_d;
    logic [31:0]               beats_rem_q, beats_rem_d;
    logic [15:0]               rows_left_q, rows_left_d;
    logic                      drop_q, drop_d;

    logic [31:0]               line_bits_c;
    logic [31:0]               bpl_c;
    logic [31:0]               stride_c;
    logic [AXI_ADDR_WIDTH-1:0] frame_addr_c;
    logic [AXI_ADDR_WIDTH-1:0] first_line_c;
    logic [AXI_ADDR_WIDTH-1:0] next_line_c;
    logic                      line_last_c;
    logic                      frame_last_c;
    logic [7:0]                len_c;
    logic                      start_ok_c;

    assign start_ok_c   = i_frame_start && (i_video_width != 16'd0) && (i_video_high != 16'd0);
    assign line_bits_c  = 32'(width_q) * 32'(PIXEL_WIDTH);
    assign bpl_c        = (line_bits_c + 32'(AXI_DATA_WIDTH - 1)) / 32'(AXI_DATA_WIDTH);
    assign stride_c     = bpl_c * BEAT_BYTES;
    assign frame_addr_c = base_q + AXI_ADDR_WIDTH'(32'(buf_q) * FRAME_BUF_STRIDE);

`ifdef VIDEO_FRAME_REVERSE_EN
    logic mode_q, mode_d;

    // Reverse order starts at the last line and walks the stride downwards.
    assign first_line_c = mode_q
        ? frame_addr_c + AXI_ADDR_WIDTH'(32'(high_q - 16'd1) * stride_c)
        : frame_addr_c;
    assign next_line_c  = mode_q ? line_addr_q - AXI_ADDR_WIDTH'(stride_q)
                                 : line_addr_q + AXI_ADDR_WIDTH'(stride_q);
`else
    logic unused_frame_mode;

    assign unused_frame_mode = i_frame_mode;
    assign first_line_c      = frame_addr_c;
    assign next_line_c       = line_addr_q + AXI_ADDR_WIDTH'(stride_q);
`endif

    assign line_last_c  = (beats_rem_q <= MAX_BEATS);
    assign frame_last_c = line_last_c && (rows_left_q == 16'd1);
    assign len_c        = line_last_c ? 8'(beats_rem_q - 32'd1) : 8'(MAX_BEATS - 32'd1);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        width_d     = width_q;
        high_d      = high_q;
        base_d      = base_q;
        stride_d    = stride_q;
        bpl_d       = bpl_q;
        line_addr_d = line_addr_q;
        off_d       = off_q;
        beats_rem_d = beats_rem_q;
        rows_left_d = rows_left_q;
        drop_d      = i_frame_start && (state_q != ST_IDLE);
`ifdef VIDEO_FRAME_REVERSE_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok_c) begin
                    width_d = i_video_width;
                    high_d  = i_video_high;
                    base_d  = i_base_addr;
`ifdef VIDEO_FRAME_REVERSE_EN
                    mode_d  = i_frame_mode;
`endif
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                stride_d    = stride_c;
                bpl_d       = bpl_c;
                line_addr_d = first_line_c;
                off_d       = 32'd0;
                beats_rem_d = bpl_c;
                rows_left_d = high_q;
                state_d     = ST_CMD;
            end
            ST_CMD: begin
                if (i_cmd_ready) begin
                    if (frame_last_c) begin
                        state_d = ST_IDLE;
                        buf_d   = (buf_q == LAST_BUF) ? 3'd0 : buf_q + 3'd1;
                    end else if (line_last_c) begin
                        line_addr_d = next_line_c;
                        off_d       = 32'd0;
                        beats_rem_d = bpl_q;
                        rows_left_d = rows_left_q - 16'd1;
                    end else begin
                        off_d       = off_q + BURST_BYTES;
                        beats_rem_d = beats_rem_q - MAX_BEATS;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= 3'd0;
            width_q     <= 16'd0;
            high_q      <= 16'd0;
            base_q      <= '0;
            stride_q    <= 32'd0;
            bpl_q       <= 32'd0;
            line_addr_q <= '0;
            off_q       <= 32'd0;
            beats_rem_q <= 32'd0;
            rows_left_q <= 16'd0;
            drop_q      <= 1'b0;
`ifdef VIDEO_FRAME_REVERSE_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            width_q     <= width_d;
            high_q      <= high_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            bpl_q       <= bpl_d;
            line_addr_q <= line_addr_d;
            off_q       <= off_d;
            beats_rem_q <= beats_rem_d;
            rows_left_q <= rows_left_d;
            drop_q      <= drop_d;
`ifdef VIDEO_FRAME_REVERSE_EN
            mode_q      <= mode_d;
`endif
        end
    end

    // Command fields are gated by valid so every output reads zero outside a frame.
    assign o_cmd_valid      = (state_q == ST_CMD);
    assign o_cmd_addr       = o_cmd_valid ? line_addr_q + AXI_ADDR_WIDTH'(off_q) : '0;
    assign o_cmd_len        = o_cmd_valid ? len_c : 8'd0;
    assign o_cmd_line_last  = o_cmd_valid && line_last_c;
    assign o_cmd_frame_last = o_cmd_valid && frame_last_c;
    assign o_buf_idx        = buf_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_frame_drop     = drop_q;
    assign o_dbg_state      = state_q;

endmodule

// File: doc/video_frame_cmd_gen.md
VIDEO_FRAME_CMD_GEN -- requirements
Module: video_frame_cmd_gen

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 128: AXI beat width in bits.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32: command address width.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 16: bits per pixel.
REQ-004 SHALL have parameter MAX_BURST_LEN, default 64: maximum beats per command, range 1..256.
REQ-005 SHALL have parameter FRAME_BUF_NUM, default 3: frame buffers in rotation, range 1..8.
REQ-006 SHALL have parameter FRAME_BUF_STRIDE, default 32'h0080_0000: byte distance between frame buffers.
REQ-007 SHALL have port i_axi_clk, input, 1: sole clock.
REQ-008 SHALL have port i_reset_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port i_frame_start, input, 1: one-cycle frame start request.
REQ-010 SHALL have port i_video_width, input, 16: pixels per line.
REQ-011 SHALL have port i_video_high, input, 16: lines per frame.
REQ-012 SHALL have port i_base_addr, input, AXI_ADDR_WIDTH: buffer 0 byte address.
REQ-013 SHALL have port i_frame_mode, input, 1: 1 = lines in reverse order, 0 = normal.
REQ-014 SHALL have port o_cmd_valid, input-side handshake output, 1: command valid.
REQ-015 SHALL have port i_cmd_ready, input, 1: command accepted when high with o_cmd_valid.
REQ-016 SHALL have port o_cmd_addr, output, AXI_ADDR_WIDTH: burst start byte address.
REQ-017 SHALL have port o_cmd_len, output, 8: burst beats minus one.
REQ-018 SHALL have ports o_cmd_line_last and o_cmd_frame_last, output, 1 each: command ends a line / a frame.
REQ-019 SHALL have port o_buf_idx, output, 3: frame buffer of the current or next frame.
REQ-020 SHALL have ports o_busy and o_frame_drop, output, 1 each: frame in progress / start rejected pulse.

Function
REQ-021 SHALL compute beats_per_line = ceil(width*PIXEL_WIDTH/AXI_DATA_WIDTH) and line_stride = beats_per_line*AXI_DATA_WIDTH/8 bytes, using 32-bit intermediates.
REQ-022 SHALL use FSM IDLE -> SETUP (one cycle: latch width, high, base, mode, buffer; compute stride) -> CMD -> IDLE.
REQ-023 SHALL leave IDLE only on i_frame_start with width and high both nonzero; a zero dimension is ignored, no command, no pulse.
REQ-024 SHALL assert o_cmd_valid the second cycle after i_frame_start is sampled.
REQ-025 SHALL split each line into bursts of MAX_BURST_LEN beats, the final burst carrying the remainder.
REQ-026 SHALL set o_cmd_addr = base + buf_idx*FRAME_BUF_STRIDE + line*line_stride + burst_offset, with line = row (normal) or high-1-row (reverse).
REQ-027 SHALL hold o_cmd_addr, o_cmd_len and the flags stable while o_cmd_valid is high and i_cmd_ready is low.
REQ-028 SHALL present the next command in the cycle after a handshake, with no bubble.
REQ-029 SHALL return to IDLE on the handshake of the o_cmd_frame_last command, deassert o_busy the next cycle, and advance o_buf_idx modulo FRAME_BUF_NUM.
REQ-030 SHALL ignore i_frame_start outside IDLE and pulse o_frame_drop for one cycle.
REQ-031 SHALL drive o_busy high in every state other than IDLE.
REQ-032 SHALL ignore later input changes during a frame, using only the values latched in SETUP.

Reset
REQ-033 SHALL, on i_reset_n low, immediately force IDLE, all outputs 0 and o_buf_idx = 0, abandoning any frame in flight.
REQ-034 SHALL resume in IDLE on the first clock edge after reset deasserts.

Configuration
REQ-035 SHALL, with macro VIDEO_FRAME_REVERSE_EN defined, honour i_frame_mode as in REQ-026.
REQ-036 SHALL, without VIDEO_FRAME_REVERSE_EN, ignore i_frame_mode and always use normal line order, with no reverse-address logic synthesised.

Verification (defaults; base = 0x1000_0000)
REQ-037 SHALL test width=64, high=2, ready=1: two commands, addr 0x1000_0000 then 0x1000_0080, len 7, both line_last, second frame_last.
REQ-038 SHALL test width=1000, high=1: len 63 at 0x1000_0000, then len 60 at 0x1000_0400, line stride 2000 bytes.
REQ-039 SHALL test width=64, high=4, mode=1 (macro on): addrs +0x180, +0x100, +0x080, +0x000.
REQ-040 SHALL test four frames: o_buf_idx 0,1,2,0, with frame 2 at 0x1100_0000.
REQ-041 SHALL test ready low 5 cycles mid-frame plus start while busy: command stable throughout, one o_frame_drop pulse, command count unchanged.
REQ-042 SHALL test i_reset_n low during the third command: outputs 0 at once, o_buf_idx 0, and the next start begins again at 0x1000_0000.
